wb_fifo_initiator: RTL and testbench

Wishbone B4 pipelined initiator that turns a simple command/response handshake into single Wishbone bus cycles. It is the bus-master counterpart of the FIFO Wishbone slave wrapper. Firmware-less engines and testbench-free subsystems use it to push to and pop from DATA, poll STATUS, and flush through CONTROL. It allows one outstanding transaction, supports slave stall, and aborts any cycle that exceeds a programmable timeout.

---
 rtl/wb_fifo_initiator_pkg.sv | 31 +++
 rtl/wb_timeout_counter.sv | 36 +++
 rtl/wb_fifo_initiator.sv | 179 +++++++++++++++++
 tb/tb_wb_fifo_initiator.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_fifo_initiator_pkg.sv
// Shared types and constants for the Wishbone FIFO initiator.
// Register map and STATUS layout match the FIFO slave wrapper.
package wb_fifo_initiator_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RSP
    } state_e;

    localparam logic [7:0] REG_DATA      = 8'h00;
    localparam logic [7:0] REG_STATUS    = 8'h04;
    localparam logic [7:0] REG_CONTROL   = 8'h08;
    localparam logic [7:0] REG_MAX_LEVEL = 8'h0C;

    localparam int STAT_EMPTY        = 0;
    localparam int STAT_FULL         = 1;
    localparam int STAT_ALMOST_EMPTY = 2;
    localparam int STAT_ALMOST_FULL  = 3;
    localparam int STAT_OVERFLOW     = 4;
    localparam int STAT_UNDERFLOW    = 5;
    localparam int STAT_LEVEL_LSB    = 16;
    localparam int STAT_LEVEL_MSB    = 31;

    // A disabled timeout still needs a one-bit counter.
    function automatic int cnt_width(input int cycles);
        return (cycles > 0) ? $clog2(cycles + 1) : 1;
    endfunction

endpackage

// File: rtl/wb_timeout_counter.sv
// Saturating cycle counter that flags the cycle on which the limit
// is reached; a zero limit never expires.
module wb_timeout_counter #(
    parameter int W = 9
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] limit,
    output logic         expired
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q < limit)) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    // True in the cycle whose closing edge brings the count to limit.
    assign expired = enable && (limit != '0) && (cnt_q >= limit - ONE);

endmodule

// File: rtl/wb_fifo_initiator.sv
// Command/response to Wishbone B4 pipelined single-cycle initiator
// with stall support and a programmable bus timeout.
module wb_fifo_initiator
    import wb_fifo_initiator_pkg::*;
#(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    wb_clk_i,
    input  logic                    wb_rst_i,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_we,
    input  logic [ADDR_WIDTH-1:0]   cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_sel,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    rsp_timeout,
    output logic                    busy,
    output logic [ADDR_WIDTH-1:0]   wb_adr_o,
    output logic [DATA_WIDTH-1:0]   wb_dat_o,
    input  logic [DATA_WIDTH-1:0]   wb_dat_i,
    output logic                    wb_we_o,
    output logic [DATA_WIDTH/8-1:0] wb_sel_o,
    output logic                    wb_cyc_o,
    output logic                    wb_stb_o,
    input  logic                    wb_ack_i,
    input  logic                    wb_err_i,
    input  logic                    wb_stall_i
);

    localparam int CW = cnt_width(TIMEOUT_CYCLES);
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

    state_e state_q, state_d;

    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    we_q, we_d;
    logic [DATA_WIDTH/8-1:0] sel_q, sel_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic                    rvld_q, rvld_d;
    logic                    rerr_q, rerr_d;
    logic                    rto_q, rto_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;

    logic on_bus;
    logic term;
    logic expired;

    assign on_bus = (state_q == ST_REQ) || (state_q == ST_WAIT);
    assign term   = wb_ack_i || wb_err_i;

    wb_timeout_counter #(.W(CW)) u_tmo (
        .clk_i   (wb_clk_i),
        .rst_i   (wb_rst_i),
        .clear   ((state_q == ST_IDLE) && cmd_valid),
        .enable  (on_bus),
        .limit   (LIMIT),
        .expired (expired)
    );

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: if (cmd_valid) state_d = ST_REQ;
            ST_REQ: begin
                if (term || expired) state_d = ST_RSP;
                else if (!wb_stall_i) state_d = ST_WAIT;
            end
            ST_WAIT: if (term || expired) state_d = ST_RSP;
            ST_RSP:  if (rsp_ready) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        adr_d  = adr_q;
        dat_d  = dat_q;
        we_d   = we_q;
        sel_d  = sel_q;
        cyc_d  = cyc_q;
        stb_d  = stb_q;
        rvld_d = rvld_q;
        rerr_d = rerr_q;
        rto_d  = rto_q;
        rdat_d = rdat_q;
        unique case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    adr_d = cmd_addr;
                    dat_d = cmd_wdata;
                    we_d  = cmd_we;
                    sel_d = cmd_sel;
                    cyc_d = 1'b1;
                    stb_d = 1'b1;
                end
            end
            ST_REQ, ST_WAIT: begin
                if (term) begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    rvld_d = 1'b1;
                    rerr_d = wb_err_i;
                    rto_d  = 1'b0;
                    rdat_d = (wb_ack_i && !wb_err_i && !we_q) ? wb_dat_i : '0;
                end else if (expired) begin
                    cyc_d  = 1'b0;
                    stb_d  = 1'b0;
                    rvld_d = 1'b1;
                    rerr_d = 1'b1;
                    rto_d  = 1'b1;
                    rdat_d = '0;
                end else if ((state_q == ST_REQ) && !wb_stall_i) begin
                    stb_d = 1'b0;
                end
            end
            ST_RSP: begin
                if (rsp_ready) begin
                    rvld_d = 1'b0;
                    rerr_d = 1'b0;
                    rto_d  = 1'b0;
                    rdat_d = '0;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            adr_q  <= '0;
            dat_q  <= '0;
            we_q   <= 1'b0;
            sel_q  <= '0;
            cyc_q  <= 1'b0;
            stb_q  <= 1'b0;
            rvld_q <= 1'b0;
            rerr_q <= 1'b0;
            rto_q  <= 1'b0;
            rdat_q <= '0;
        end else begin
            adr_q  <= adr_d;
            dat_q  <= dat_d;
            we_q   <= we_d;
            sel_q  <= sel_d;
            cyc_q  <= cyc_d;
            stb_q  <= stb_d;
            rvld_q <= rvld_d;
            rerr_q <= rerr_d;
            rto_q  <= rto_d;
            rdat_q <= rdat_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign wb_adr_o    = adr_q;
    assign wb_dat_o    = dat_q;
    assign wb_we_o     = we_q;
    assign wb_sel_o    = sel_q;
    assign wb_cyc_o    = cyc_q;
    assign wb_stb_o    = stb_q;
    assign rsp_valid   = rvld_q;
    assign rsp_err     = rerr_q;
    assign rsp_timeout = rto_q;
    assign rsp_rdata   = rdat_q;

endmodule

// File: tb/tb_wb_fifo_initiator.sv
// Directed bench for wb_fifo_initiator: vector table of single
// transactions plus hand-written back-pressure, late-ack and reset cases.
module tb_wb_fifo_initiator;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [31:0] cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [3:0]  cmd_sel = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic        busy;
    logic [31:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_we_o;
    logic [3:0]  wb_sel_o;
    logic        wb_cyc_o;
    logic        wb_stb_o;
    logic        wb_ack_i = 1'b0;
    logic        wb_err_i = 1'b0;
    logic        wb_stall_i = 1'b0;

    int checks = 0;
    int failures = 0;

    wb_fifo_initiator #(
        .ADDR_WIDTH(32),
        .DATA_WIDTH(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .wb_clk_i    (clk),
        .wb_rst_i    (rst),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_we      (cmd_we),
        .cmd_addr    (cmd_addr),
        .cmd_wdata   (cmd_wdata),
        .cmd_sel     (cmd_sel),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_rdata   (rsp_rdata),
        .rsp_err     (rsp_err),
        .rsp_timeout (rsp_timeout),
        .busy        (busy),
        .wb_adr_o    (wb_adr_o),
        .wb_dat_o    (wb_dat_o),
        .wb_dat_i    (wb_dat_i),
        .wb_we_o     (wb_we_o),
        .wb_sel_o    (wb_sel_o),
        .wb_cyc_o    (wb_cyc_o),
        .wb_stb_o    (wb_stb_o),
        .wb_ack_i    (wb_ack_i),
        .wb_err_i    (wb_err_i),
        .wb_stall_i  (wb_stall_i)
    );

    always #5 clk = ~clk;

    // stall_n: cycles 1..stall_n stalled; term_at: cycle of ack/err (0 = never)
    typedef struct {
        string       name;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  sel;
        int          stall_n;
        int          term_at;
        logic        ack;
        logic        err;
        logic [31:0] dat;
        logic [31:0] x_rdata;
        logic        x_err;
        logic        x_to;
        int          x_lat;
        int          x_stb;
        int          x_cyc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic bus_idle();
        wb_ack_i   = 1'b0;
        wb_err_i   = 1'b0;
        wb_stall_i = 1'b0;
        wb_dat_i   = '0;
    endtask

    // Called at a negedge; returns at the negedge of cycle 1.
    task automatic send_cmd(input logic we, input logic [31:0] a,
                            input logic [31:0] d, input logic [3:0] s);
        chk("cmd_ready_before_cmd", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_sel   = s;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic handshake(input string nm);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk({nm, "_rsp_cleared"}, 32'(rsp_valid), 32'd0);
        chk({nm, "_back_idle"}, 32'(cmd_ready), 32'd1);
    endtask

    task automatic run_vec(input vec_t v);
        int stb_n = 0;
        int cyc_n = 0;
        int lat = 0;
        int bad = 0;
        send_cmd(v.we, v.addr, v.wdata, v.sel);
        for (int k = 1; k <= 40 && lat == 0; k++) begin
            bus_idle();
            if (rsp_valid) begin
                lat = k;
            end else begin
                if (wb_cyc_o) begin
                    cyc_n++;
                    if (wb_adr_o !== v.addr || wb_we_o !== v.we ||
                        wb_sel_o !== v.sel || wb_dat_o !== v.wdata)
                        bad++;
                end
                if (wb_stb_o) stb_n++;
                wb_stall_i = (k <= v.stall_n);
                if (k == v.term_at) begin
                    wb_ack_i = v.ack;
                    wb_err_i = v.err;
                    wb_dat_i = v.dat;
                end
                @(negedge clk);
            end
        end
        chk({v.name, "_latency"}, 32'(lat), 32'(v.x_lat));
        chk({v.name, "_stb_cycles"}, 32'(stb_n), 32'(v.x_stb));
        chk({v.name, "_cyc_cycles"}, 32'(cyc_n), 32'(v.x_cyc));
        chk({v.name, "_bus_stable_errs"}, 32'(bad), 32'd0);
        chk({v.name, "_rdata"}, rsp_rdata, v.x_rdata);
        chk({v.name, "_err"}, 32'(rsp_err), 32'(v.x_err));
        chk({v.name, "_timeout"}, 32'(rsp_timeout), 32'(v.x_to));
        chk({v.name, "_cmd_ready_in_rsp"}, 32'(cmd_ready), 32'd0);
        handshake(v.name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got running expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        vecs[0] = '{"zero_wait_wr", 1'b1, 32'h0, 32'hA5A5_0001, 4'hF,
                    0, 1, 1'b1, 1'b0, 32'hDEAD_BEEF,
                    32'h0, 1'b0, 1'b0, 2, 1, 1};
        vecs[1] = '{"stalled_rd", 1'b0, 32'h4, 32'h0, 4'hF,
                    3, 5, 1'b1, 1'b0, 32'h0003_0008,
                    32'h0003_0008, 1'b0, 1'b0, 6, 4, 5};
        vecs[2] = '{"slave_err", 1'b1, 32'hC, 32'h1234_5678, 4'hF,
                    0, 1, 1'b1, 1'b1, 32'hFFFF_FFFF,
                    32'h0, 1'b1, 1'b0, 2, 1, 1};
        vecs[3] = '{"timeout_wait", 1'b0, 32'h8, 32'h0, 4'hF,
                    0, 0, 1'b0, 1'b0, 32'h0,
                    32'h0, 1'b1, 1'b1, 9, 1, 8};
        vecs[4] = '{"timeout_stall", 1'b0, 32'h8, 32'h0, 4'hF,
                    20, 0, 1'b0, 1'b0, 32'h0,
                    32'h0, 1'b1, 1'b1, 9, 8, 8};
        vecs[5] = '{"ack_in_stall", 1'b0, 32'h0, 32'h0, 4'hF,
                    5, 2, 1'b1, 1'b0, 32'h0000_1234,
                    32'h0000_1234, 1'b0, 1'b0, 3, 2, 2};
        vecs[6] = '{"err_rd", 1'b0, 32'h4, 32'h0, 4'hF,
                    0, 3, 1'b0, 1'b1, 32'hFFFF_0000,
                    32'h0, 1'b1, 1'b0, 4, 1, 3};
        vecs[7] = '{"ack_at_limit", 1'b0, 32'h0, 32'h0, 4'hF,
                    0, 8, 1'b1, 1'b0, 32'h0000_0077,
                    32'h0000_0077, 1'b0, 1'b0, 9, 1, 8};
        vecs[8] = '{"wr_after_stall", 1'b1, 32'h0, 32'hCAFE_F00D, 4'h3,
                    2, 3, 1'b1, 1'b0, 32'h5555_5555,
                    32'h0, 1'b0, 1'b0, 4, 3, 3};

        bus_idle();
        repeat (2) @(negedge clk);
        chk("rst_cyc", 32'(wb_cyc_o), 32'd0);
        chk("rst_stb", 32'(wb_stb_o), 32'd0);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_adr", wb_adr_o, 32'h0);
        chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        foreach (vecs[i]) run_vec(vecs[i]);

        // Stray ack in IDLE is ignored.
        wb_ack_i = 1'b1;
        @(negedge clk);
        wb_ack_i = 1'b0;
        chk("stray_idle_rsp", 32'(rsp_valid), 32'd0);
        chk("stray_idle_busy", 32'(busy), 32'd0);

        // Late ack after a timeout abort leaves the response untouched.
        send_cmd(1'b0, 32'h8, 32'h0, 4'hF);
        repeat (7) @(negedge clk);
        chk("late_cyc_c8", 32'(wb_cyc_o), 32'd1);
        @(negedge clk);
        chk("late_cyc_c9", 32'(wb_cyc_o), 32'd0);
        chk("late_rsp_c9", 32'(rsp_valid), 32'd1);
        repeat (2) @(negedge clk);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'hBAD0_BAD0;
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        chk("late_rsp_held", 32'(rsp_valid), 32'd1);
        chk("late_to_held", 32'(rsp_timeout), 32'd1);
        chk("late_err_held", 32'(rsp_err), 32'd1);
        chk("late_rdata", rsp_rdata, 32'h0);
        chk("late_cyc", 32'(wb_cyc_o), 32'd0);
        handshake("late");

        // Back-pressure with the next command already offered.
        send_cmd(1'b0, 32'h4, 32'h0, 4'hF);
        wb_ack_i = 1'b1;
        wb_dat_i = 32'h0000_00C3;
        @(negedge clk);
        bus_idle();
        cmd_valid = 1'b1;
        cmd_we    = 1'b1;
        cmd_addr  = 32'h10;
        cmd_wdata = 32'h0BAD_CAFE;
        cmd_sel   = 4'hF;
        held = rsp_rdata;
        chk("bp_rdata", held, 32'h0000_00C3);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid_held", 32'(rsp_valid), 32'd1);
            chk("bp_rdata_held", rsp_rdata, held);
            chk("bp_cmd_ready", 32'(cmd_ready), 32'd0);
            chk("bp_cyc", 32'(wb_cyc_o), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        chk("bp_idle_cycle_cyc", 32'(wb_cyc_o), 32'd0);
        chk("bp_idle_cmd_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
        chk("bp_next_cyc", 32'(wb_cyc_o), 32'd1);
        chk("bp_next_adr", wb_adr_o, 32'h10);
        chk("bp_next_dat", wb_dat_o, 32'h0BAD_CAFE);
        wb_ack_i = 1'b1;
        @(negedge clk);
        bus_idle();
        handshake("bp_next");

        // Reset while waiting for the slave.
        send_cmd(1'b0, 32'h4, 32'h0, 4'hF);
        @(negedge clk);
        chk("rstmid_cyc_before", 32'(wb_cyc_o), 32'd1);
        chk("rstmid_stb_before", 32'(wb_stb_o), 32'd0);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_cyc_async", 32'(wb_cyc_o), 32'd0);
        chk("rstmid_busy_async", 32'(busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rstmid_cmd_ready", 32'(cmd_ready), 32'd1);
        chk("rstmid_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rstmid_cyc", 32'(wb_cyc_o), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
